raster_scan_gen: RTL and testbench
==================================

Name: raster_scan_gen

Overview:
- Programmable 2-D raster scan generator; next generation of the fixed-size 2-D counter.
- Emits one (x, y, linear address) tuple per accepted beat over a runtime-configured window, with pitch/base address arithmetic, frame/line markers, one-shot or continuous modes and a valid/ready output handshake.
- Sits between the frame controller and pixel fetch/draw pipelines; downstream may stall it.

Parameters:
- MAX_W, 640, largest window width supported.
- MAX_H, 480, largest window height supported.
- X_BITS, $clog2(MAX_W), coordinate width for x.
- Y_BITS, $clog2(MAX_H), coordinate width for y.
- CW_BITS, $clog2(MAX_W+1), width of cfg_width.
- CH_BITS, $clog2(MAX_H+1), width of cfg_height.
- ADDR_BITS, 20, linear address / pitch / base width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  latch config and begin scan (honoured in IDLE only)
- stop  in  1  abort scan
- cfg_width  in  CW_BITS  window width W
- cfg_height  in  CH_BITS  window height H
- cfg_pitch  in  ADDR_BITS  address increment per line
- cfg_base  in  ADDR_BITS  address of (0,0)
- cfg_continuous  in  1  1 = restart after last beat, 0 = one-shot
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_x  out  X_BITS  column
- out_y  out  Y_BITS  row
- out_addr  out  ADDR_BITS  base + y*pitch + x, mod 2^ADDR_BITS
- out_sol / out_eol  out  1  x==0 / x==W-1 (qualified by out_valid)
- out_sof / out_eof  out  1  (0,0) / (W-1,H-1) (qualified by out_valid)
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse per completed frame
- cfg_err  out  1  one-cycle pulse, rejected config

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset has priority over all other inputs. On reset, state = IDLE and every output register clears to 0: out_valid, x, y, addr, busy, done, cfg_err. Reset mid-scan aborts immediately.
- Beat handshake: a beat transfers on a clk edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_x, out_y, out_addr and all flags stay constant.
  - out_valid is never retracted without a transfer, except by stop or rst.
- IDLE:
  - busy=0, out_valid=0.
  - A start pulse latches all cfg_* inputs into internal registers; later cfg changes have no effect until the next start.
  - If W==0, H==0, W>MAX_W or H>MAX_H: cfg_err=1 for the next cycle only, and state stays IDLE.
  - Otherwise the next cycle enters RUN with x=0, y=0, addr=base, out_valid=1, busy=1. First beat is presented 1 cycle after start.
- RUN, advance on each transfer:
  - Not at end of line: x+1, addr+1.
  - At end of line (x==W-1): x=0, y+1, addr=line_addr+pitch, where line_addr tracks the start address of the current row. No multiplier.
  - Last beat (x=W-1, y=H-1) transferred: done=1 on the following cycle.
    - One-shot: go to IDLE, out_valid=0 on that cycle.
    - Continuous: x=0, y=0, addr=base, out_valid stays 1 with no bubble.
- start while RUN is ignored.
- stop in RUN: next cycle is IDLE with out_valid=0 and no done. A transfer occurring on that same edge still counts. stop in IDLE has no effect.
- stop and start together in IDLE: start wins.
- W=1 and/or H=1: all flags may assert together on a single beat. A 1x1 one-shot produces exactly one beat then done.
- Address arithmetic wraps modulo 2^ADDR_BITS with no error.
- done and cfg_err never assert in the same cycle.

Test Plan:
- W=3, H=2, base=0x100, pitch=8, one-shot, ready=1 → six beats (0,0)0x100, (1,0)0x101, (2,0)0x102, (0,1)0x108, (1,1)0x109, (2,1)0x10A.
  - sof on beat 1; eol on beats 3 and 6; eof on beat 6.
  - done one cycle after beat 6; busy then 0.
- Same config with ready toggling 1,0,0,1,… → outputs held during stalls; identical beat sequence; done only after the 6th transfer.
- W=2, H=2, continuous, ready=1 → beats repeat (0,0),(1,0),(0,1),(1,1),(0,0)… with no invalid cycle; done pulses every 4 beats.
- start with W=0, then start with W=MAX_W+1 → cfg_err pulse each time; no out_valid; busy stays 0.
- stop asserted after 3rd transfer of a 4x4 scan → out_valid=0 next cycle, no done. A new start with W=2, H=1 then scans from (0,0) at the new base.
- base=0xFFFFE, pitch=1, W=4, H=1 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001. Also assert rst mid-scan → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/raster_scan_gen.sv
// Programmable 2-D raster scan generator.
// Walks a runtime-configured W x H window row by row and emits one
// (x, y, linear address) beat per accepted transfer. The address is tracked
// incrementally from a per-row start address, so no multiplier is needed.
// Supports one-shot or continuous scanning and a valid/ready output that
// downstream may stall.
module raster_scan_gen #(
    parameter int MAX_W     = 640,
    parameter int MAX_H     = 480,
    parameter int X_BITS    = $clog2(MAX_W),
    parameter int Y_BITS    = $clog2(MAX_H),
    parameter int CW_BITS   = $clog2(MAX_W + 1),
    parameter int CH_BITS   = $clog2(MAX_H + 1),
    parameter int ADDR_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CW_BITS-1:0]   cfg_width,
    input  logic [CH_BITS-1:0]   cfg_height,
    input  logic [ADDR_BITS-1:0] cfg_pitch,
    input  logic [ADDR_BITS-1:0] cfg_base,
    input  logic                 cfg_continuous,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [X_BITS-1:0]    out_x,
    output logic [Y_BITS-1:0]    out_y,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic                 out_sol,
    output logic                 out_eol,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW_BITS-1:0]   w_q, w_d;
    logic [CH_BITS-1:0]   h_q, h_d;
    logic [ADDR_BITS-1:0] pitch_q, pitch_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic                 cont_q, cont_d;
    logic [X_BITS-1:0]    x_q, x_d;
    logic [Y_BITS-1:0]    y_q, y_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] line_q, line_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 sol_q, sol_d;
    logic                 eol_q, eol_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;

    logic                 at_eol_s;
    logic                 at_eof_s;
    logic                 cfg_bad_s;

    // Next-state, coordinate/address advance and beat flag computation.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        pitch_d   = pitch_q;
        base_d    = base_q;
        cont_d    = cont_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        line_d    = line_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        at_eol_s  = (CW_BITS'(x_q) == (w_q - CW_BITS'(1)));
        at_eof_s  = at_eol_s && (CH_BITS'(y_q) == (h_q - CH_BITS'(1)));
        cfg_bad_s = (cfg_width == {CW_BITS{1'b0}}) || (cfg_height == {CH_BITS{1'b0}}) ||
                    (cfg_width > CW_BITS'(MAX_W)) || (cfg_height > CH_BITS'(MAX_H));

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    // Config is captured even when rejected; it is only used once RUN is entered.
                    w_d     = cfg_width;
                    h_d     = cfg_height;
                    pitch_d = cfg_pitch;
                    base_d  = cfg_base;
                    cont_d  = cfg_continuous;
                    if (cfg_bad_s) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        x_d     = {X_BITS{1'b0}};
                        y_d     = {Y_BITS{1'b0}};
                        addr_d  = cfg_base;
                        line_d  = cfg_base;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_q && out_ready) begin
                    if (at_eof_s) begin
                        done_d = 1'b1;
                        x_d    = {X_BITS{1'b0}};
                        y_d    = {Y_BITS{1'b0}};
                        addr_d = base_q;
                        line_d = base_q;
                        if (!cont_q) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else if (at_eol_s) begin
                        x_d    = {X_BITS{1'b0}};
                        y_d    = y_q + Y_BITS'(1);
                        line_d = line_q + pitch_q;
                        addr_d = line_q + pitch_q;
                    end else begin
                        x_d    = x_q + X_BITS'(1);
                        addr_d = addr_q + ADDR_BITS'(1);
                    end
                end else begin
                    valid_d = valid_q;
                end
                // Abort wins over the advance: the beat on this edge is consumed, but no done.
                if (stop) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    busy_d  = busy_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Flags describe the beat that will be presented next cycle.
        sol_d = valid_d && (x_d == {X_BITS{1'b0}});
        eol_d = valid_d && (CW_BITS'(x_d) == (w_d - CW_BITS'(1)));
        sof_d = sol_d && (y_d == {Y_BITS{1'b0}});
        eof_d = eol_d && (CH_BITS'(y_d) == (h_d - CH_BITS'(1)));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            w_q       <= {CW_BITS{1'b0}};
            h_q       <= {CH_BITS{1'b0}};
            pitch_q   <= {ADDR_BITS{1'b0}};
            base_q    <= {ADDR_BITS{1'b0}};
            cont_q    <= 1'b0;
            x_q       <= {X_BITS{1'b0}};
            y_q       <= {Y_BITS{1'b0}};
            addr_q    <= {ADDR_BITS{1'b0}};
            line_q    <= {ADDR_BITS{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            sol_q     <= 1'b0;
            eol_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            pitch_q   <= pitch_d;
            base_q    <= base_d;
            cont_q    <= cont_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            sol_q     <= sol_d;
            eol_q     <= eol_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
        end
    end

    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_addr  = addr_q;
    assign out_sol   = sol_q;
    assign out_eol   = eol_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Self-checking bench for raster_scan_gen: directed scenarios plus randomized
// scans, checked against a frame-level model that lists every expected beat.
module tb_raster_scan_gen;

    localparam int MAX_W = 640;
    localparam int MAX_H = 480;
    localparam int XB = $clog2(MAX_W);
    localparam int YB = $clog2(MAX_H);
    localparam int CWB = $clog2(MAX_W + 1);
    localparam int CHB = $clog2(MAX_H + 1);
    localparam int AB = 20;

    logic clk = 1'b0;
    logic rst, start, stop, cfg_continuous, out_ready;
    logic [CWB-1:0] cfg_width;
    logic [CHB-1:0] cfg_height;
    logic [AB-1:0]  cfg_pitch, cfg_base;
    logic out_valid, out_sol, out_eol, out_sof, out_eof, busy, done, cfg_err;
    logic [XB-1:0] out_x;
    logic [YB-1:0] out_y;
    logic [AB-1:0] out_addr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int y;
        logic [AB-1:0] addr;
        bit sol, eol, sof, eof, last;
    } beat_t;

    beat_t exp_q[$];

    raster_scan_gen #(.MAX_W(MAX_W), .MAX_H(MAX_H), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_pitch(cfg_pitch), .cfg_base(cfg_base),
        .cfg_continuous(cfg_continuous),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_addr(out_addr),
        .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: one frame is every (x,y) in row-major order, address = base + y*pitch + x.
    task automatic push_frame(input int w, input int h, input logic [AB-1:0] base,
                              input logic [AB-1:0] pitch);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                beat_t b;
                longint a;
                a = longint'(base) + longint'(y) * longint'(pitch) + longint'(x);
                b.x = x; b.y = y;
                b.addr = a[AB-1:0];
                b.sol = (x == 0); b.eol = (x == w - 1);
                b.sof = (x == 0) && (y == 0);
                b.eof = (x == w - 1) && (y == h - 1);
                b.last = b.eof;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int w, input int h, input logic [AB-1:0] base,
                             input logic [AB-1:0] pitch, input bit cont);
        cfg_width = CWB'(w); cfg_height = CHB'(h);
        cfg_base = base; cfg_pitch = pitch; cfg_continuous = cont;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // stop_at: assert stop once this many transfers are done (-1 never).
    // jitter: disturb cfg inputs and pulse start during RUN.
    task automatic scan(input int w, input int h, input logic [AB-1:0] base,
                        input logic [AB-1:0] pitch, input bit cont, input int nframes,
                        input int ready_mode, input int stop_at, input bit jitter);
        int transfers = 0, frames_done = 0, cycles = 0;
        bit done_exp = 1'b0, ended = 1'b0, do_stop;
        beat_t e;
        exp_q.delete();
        push_frame(w, h, base, pitch);
        drive_cfg(w, h, base, pitch, cont);
        start = 1'b1; stop = 1'b0;
        tick();
        start = 1'b0;
        forever begin
            check_eq("done", 32'(done), 32'(done_exp));
            check_eq("cfg_err", 32'(cfg_err), 32'd0);
            done_exp = 1'b0;
            if (ended) begin
                check_idle_zero("end");
                break;
            end
            check_eq("valid", 32'(out_valid), 32'd1);
            check_eq("busy", 32'(busy), 32'd1);
            e = exp_q[0];
            check_eq("x", 32'(out_x), 32'(e.x));
            check_eq("y", 32'(out_y), 32'(e.y));
            check_eq("addr", 32'(out_addr), 32'(e.addr));
            check_eq("flags", {28'd0, out_sol, out_eol, out_sof, out_eof},
                     {28'd0, e.sol, e.eol, e.sof, e.eof});
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((cycles % 3) == 0);
                default: out_ready = ($urandom_range(0, 99) < 70);
            endcase
            do_stop = (transfers == stop_at) || (cont && frames_done >= nframes);
            stop = do_stop;
            if (jitter) begin
                drive_cfg($urandom_range(0, 9), $urandom_range(0, 9), AB'($urandom),
                          AB'($urandom), 1'($urandom));
                start = ($urandom_range(0, 3) == 0);
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                transfers++;
                if (e.last) begin
                    frames_done++;
                    done_exp = 1'b1;
                    if (cont) push_frame(w, h, base, pitch);
                    else ended = 1'b1;
                end
            end
            if (do_stop) begin
                ended = 1'b1;
                done_exp = 1'b0;
            end
            tick();
            start = 1'b0; stop = 1'b0;
            cycles++;
            if (cycles > 20000) begin
                check_eq("scan_timeout", 32'(cycles), 32'd20000);
                break;
            end
        end
    endtask

    task automatic bad_start(input int w, input int h);
        drive_cfg(w, h, 20'h00123, 20'h00010, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("cfg_err_pulse", 32'(cfg_err), 32'd1);
        check_eq("cfg_err_done", 32'(done), 32'd0);
        check_idle_zero("cfg_err");
        tick();
        check_eq("cfg_err_clear", 32'(cfg_err), 32'd0);
        check_idle_zero("cfg_err2");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        drive_cfg(0, 0, 20'h0, 20'h0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_eq("rst_addr", 32'(out_addr), 32'd0);
        check_eq("rst_xy", {12'd0, 10'(out_x), 10'(out_y)}, 32'd0);
        tick();

        // Stop while idle is harmless.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle_zero("idle_stop");

        // Basic 3x2 one-shot, then the stalled variant.
        scan(3, 2, 20'h00100, 20'h00008, 1'b0, 1, 0, -1, 1'b0);
        scan(3, 2, 20'h00100, 20'h00008, 1'b0, 1, 1, -1, 1'b0);
        // 2x2 continuous, three frames.
        scan(2, 2, 20'h00040, 20'h00004, 1'b1, 3, 0, -1, 1'b0);
        // Rejected configs.
        bad_start(0, 2);
        bad_start(MAX_W + 1, 2);
        bad_start(3, 0);
        bad_start(3, MAX_H + 1);
        // Stop after three transfers, then a fresh small scan.
        scan(4, 4, 20'h00200, 20'h00010, 1'b0, 1, 0, 3, 1'b0);
        scan(2, 1, 20'h00777, 20'h00010, 1'b0, 1, 0, -1, 1'b0);
        // Address wrap and single-pixel windows.
        scan(4, 1, 20'hFFFFE, 20'h00001, 1'b0, 1, 0, -1, 1'b0);
        scan(1, 1, 20'h00055, 20'h00003, 1'b0, 1, 2, -1, 1'b0);
        scan(1, 3, 20'hFFFF0, 20'h00009, 1'b1, 2, 2, -1, 1'b0);
        scan(MAX_W, 1, 20'h00000, 20'h00000, 1'b0, 1, 0, -1, 1'b0);
        scan(2, MAX_H, 20'hFFF00, 20'h00400, 1'b0, 1, 0, -1, 1'b0);

        // Randomized scans with stalls, stops, and cfg/start disturbance during RUN.
        for (int i = 0; i < 30; i++) begin
            int w, h, sa;
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 6);
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w * h) : -1;
            scan(w, h, AB'($urandom), AB'($urandom), 1'($urandom), $urandom_range(1, 3),
                 2, sa, 1'($urandom));
        end

        // Reset in the middle of a scan clears every output.
        drive_cfg(8, 8, 20'h12345, 20'h00100, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_addr", 32'(out_addr), 32'd0);
        check_eq("midrst_xy", {12'd0, 10'(out_x), 10'(out_y)}, 32'd0);
        check_eq("midrst_flags", {28'd0, out_sol, out_eol, out_sof, out_eof}, 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_cfg_err", 32'(cfg_err), 32'd0);
        tick();
        scan(3, 2, 20'h00100, 20'h00008, 1'b0, 1, 2, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
